muldiv_controller: RTL

Sequencing controller for the 64-bit HI/LO register in the CPU execute stage. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from the pipeline and runs 32-iteration shift-add multiplies and restoring divides. It drives the HI/LO register's write-enable and write-data with exactly one write per completed operation. It stalls the pipeline when a new request or an MFHI/MFLO read would race an operation still in flight.

---
 rtl/muldiv_controller_pkg.sv | 23 ++
 rtl/muldiv_controller_if.sv | 28 ++
 rtl/muldiv_step.sv | 44 ++++
 rtl/muldiv_controller.sv | 128 ++++++++++++
 4 files changed

// File: rtl/muldiv_controller_pkg.sv
// Shared definitions for the HI/LO multiply/divide controller.
// Holds the operation codes, the FSM state encoding, the iteration count
// and the op-code type used by the interface and the controller.
package muldiv_controller_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_MULT  = 3'd0;
  localparam op_t OP_MULTU = 3'd1;
  localparam op_t OP_DIV   = 3'd2;
  localparam op_t OP_DIVU  = 3'd3;
  localparam op_t OP_MTHI  = 3'd4;
  localparam op_t OP_MTLO  = 3'd5;

  localparam int MD_ITERS = 32;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

endpackage

// File: rtl/muldiv_controller_if.sv
// Pipeline <-> multiply/divide controller bus.
//   master : pipeline side (drives request, operands, flush, mf_req, hilo_q)
//   slave  : controller side (drives HI/LO write port, busy, stall)
interface muldiv_controller_if;

  logic                       start;
  muldiv_controller_pkg::op_t op;
  logic [31:0]                rs_val;
  logic [31:0]                rt_val;
  logic                       flush;
  logic                       mf_req;
  logic [63:0]                hilo_q;
  logic                       hilo_wr_en;
  logic [63:0]                hilo_wr_data;
  logic                       busy;
  logic                       stall;

  modport master (
    output start, op, rs_val, rt_val, flush, mf_req, hilo_q,
    input  hilo_wr_en, hilo_wr_data, busy, stall
  );

  modport slave (
    input  start, op, rs_val, rt_val, flush, mf_req, hilo_q,
    output hilo_wr_en, hilo_wr_data, busy, stall
  );

endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration of the multiply/divide datapath.
//   acc_in/acc_out : multiply -> 64-bit shift-add accumulator
//                    divide   -> partial remainder in acc[32:0]
//   quo_in/quo_out : divide   -> dividend bits shifting out, quotient bits in
//   opnd           : multiplicand (multiply) or divisor (divide)
//   is_div         : selects the restoring-divide step
module muldiv_step (
  input  logic [63:0] acc_in,
  input  logic [31:0] quo_in,
  input  logic [31:0] opnd,
  input  logic        is_div,
  output logic [63:0] acc_out,
  output logic [31:0] quo_out
);

  always_comb begin
    logic [32:0] sum;
    logic [32:0] rem_sh;
    logic [32:0] diff;
    sum     = '0;
    rem_sh  = '0;
    diff    = '0;
    acc_out = acc_in;
    quo_out = quo_in;
    if (is_div) begin
      // Remainder is always below the divisor, so the shifted value fits in
      // 33 bits and bit 32 of the difference is a reliable borrow flag.
      rem_sh = {acc_in[31:0], quo_in[31]};
      diff   = rem_sh - {1'b0, opnd};
      if (diff[32]) begin
        acc_out = {31'd0, rem_sh};
        quo_out = {quo_in[30:0], 1'b0};
      end else begin
        acc_out = {31'd0, diff};
        quo_out = {quo_in[30:0], 1'b1};
      end
    end else begin
      // Multiplier sits in the low half and is consumed LSB first.
      sum     = {1'b0, acc_in[63:32]} + (acc_in[0] ? {1'b0, opnd} : 33'd0);
      acc_out = {sum, acc_in[31:1]};
    end
  end

endmodule

// File: rtl/muldiv_controller.sv
// HI/LO sequencing controller for the execute stage.
// Runs 32-iteration shift-add multiplies and restoring divides on operand
// magnitudes, fixes up signs in DONE, and issues one HI/LO write per
// completed operation. MTHI/MTLO write combinationally from IDLE.
//   clk_cpu : CPU clock
//   reset   : asynchronous, active-high; returns the FSM to IDLE
//   bus     : slave side of muldiv_controller_if
module muldiv_controller import muldiv_controller_pkg::*; (
  input  logic           clk_cpu,
  input  logic           reset,
  muldiv_controller_if.slave bus
);

  function automatic logic [31:0] neg32(input logic signed [31:0] v);
    return 32'(-v);
  endfunction

  function automatic logic [63:0] neg64(input logic signed [63:0] v);
    return 64'(-v);
  endfunction

  function automatic logic [31:0] mag32(input logic signed [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? neg32(v) : v;
  endfunction

  md_state_t   state;
  logic [4:0]  cnt;
  logic        is_div_q;
  logic        neg_a_q;
  logic        neg_b_q;
  logic        dz_q;
  logic [31:0] rs_q;
  logic [31:0] opnd_q;
  logic [31:0] quo_q;
  logic [63:0] acc_q;
  logic [63:0] acc_nx;
  logic [31:0] quo_nx;
  logic [63:0] result;

  // A flush in the same cycle as a start cancels the request.
  logic req_md;
  logic req_mt;
  logic op_signed;
  assign req_md    = bus.start & ~bus.flush & (bus.op <= OP_DIVU);
  assign req_mt    = bus.start & ~bus.flush & ((bus.op == OP_MTHI) | (bus.op == OP_MTLO));
  assign op_signed = (bus.op == OP_MULT) | (bus.op == OP_DIV);

  muldiv_step u_step (
    .acc_in  (acc_q),
    .quo_in  (quo_q),
    .opnd    (opnd_q),
    .is_div  (is_div_q),
    .acc_out (acc_nx),
    .quo_out (quo_nx)
  );

  always_ff @(posedge clk_cpu or posedge reset) begin
    if (reset) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        MD_IDLE: if (req_md) begin
          state <= MD_RUN;
          cnt   <= '0;
        end
        MD_RUN: if (bus.flush) begin
          state <= MD_IDLE;
        end else begin
          cnt <= cnt + 5'd1;
          if (cnt == 5'(MD_ITERS - 1)) state <= MD_DONE;
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_cpu) begin
    if (state == MD_IDLE && req_md) begin
      is_div_q <= bus.op[1];
      neg_a_q  <= op_signed & bus.rs_val[31];
      neg_b_q  <= op_signed & bus.rt_val[31];
      dz_q     <= (bus.rt_val == 32'd0);
      rs_q     <= bus.rs_val;
      if (bus.op[1]) begin
        acc_q  <= '0;
        quo_q  <= mag32(bus.rs_val, op_signed);
        opnd_q <= mag32(bus.rt_val, op_signed);
      end else begin
        acc_q  <= {32'd0, mag32(bus.rt_val, op_signed)};
        quo_q  <= '0;
        opnd_q <= mag32(bus.rs_val, op_signed);
      end
    end else if (state == MD_RUN) begin
      acc_q <= acc_nx;
      quo_q <= quo_nx;
    end
  end

  // Sign fix-up. Neg flags are only set for signed ops, so unsigned ops
  // pass straight through. The 0x80000000 / -1 case wraps naturally.
  always_comb begin
    logic [31:0] q;
    logic [31:0] r;
    q = (neg_a_q ^ neg_b_q) ? neg32(quo_q) : quo_q;
    r = neg_a_q ? neg32(acc_q[31:0]) : acc_q[31:0];
    if (!is_div_q)  result = (neg_a_q ^ neg_b_q) ? neg64(acc_q) : acc_q;
    else if (dz_q)  result = {rs_q, 32'hFFFF_FFFF};
    else            result = {r, q};
  end

  always_comb begin
    bus.hilo_wr_en   = 1'b0;
    bus.hilo_wr_data = '0;
    if (state == MD_IDLE && req_mt) begin
      bus.hilo_wr_en   = 1'b1;
      bus.hilo_wr_data = (bus.op == OP_MTHI) ? {bus.rs_val, bus.hilo_q[31:0]}
                                             : {bus.hilo_q[63:32], bus.rs_val};
    end else if (state == MD_DONE && !bus.flush) begin
      bus.hilo_wr_en   = 1'b1;
      bus.hilo_wr_data = result;
    end
  end

  assign bus.busy  = (state != MD_IDLE);
  assign bus.stall = bus.busy & (bus.start | bus.mf_req);

endmodule
